// File: rtl/armleocpu_mem_wbuf_pkg.sv
// Shared types for the memory write buffer: sequencer state encoding and
// the lane-count derivation used by every module that splits a word into lanes.
package armleocpu_mem_wbuf_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } wbuf_state_t;

  function automatic int lane_count(input int width, input int granulity);
    return width / granulity;
  endfunction

endpackage

// File: rtl/armleocpu_bytemerge.sv
// Per-lane select between two words: lanes with sel_i set take a_i, others take b_i.
// Purely combinational.
module armleocpu_bytemerge
  import armleocpu_mem_wbuf_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int GRANULITY = 8,
  localparam int LANES    = lane_count(WIDTH, GRANULITY)
) (
  input  logic [LANES-1:0] sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign y_o[i*GRANULITY +: GRANULITY] = sel_i[i] ? a_i[i*GRANULITY +: GRANULITY]
                                                    : b_i[i*GRANULITY +: GRANULITY];
  end

endmodule

// File: rtl/armleocpu_mem_wbuf.sv
// Single-entry write buffer in front of a 1RW byte-enable array; reads win the port,
// the buffer drains in read-free cycles. ARMLEOCPU_MEM_WBUF_INIT_EN adds a zero-fill walk after reset.
module armleocpu_mem_wbuf
  import armleocpu_mem_wbuf_pkg::*;
#(
  parameter int ELEMENTS_W = 7,
  parameter int WIDTH      = 32,
  parameter int GRANULITY  = 8,
  localparam int LANES     = lane_count(WIDTH, GRANULITY)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ELEMENTS_W-1:0] req_address_i,
  input  logic [LANES-1:0]      req_writeenable_i,
  input  logic [WIDTH-1:0]      req_writedata_i,
  output logic                  resp_valid_o,
  output logic [WIDTH-1:0]      resp_readdata_o,
  output logic                  busy_o,
  output logic [ELEMENTS_W-1:0] mem_address_o,
  output logic                  mem_read_o,
  input  logic [WIDTH-1:0]      mem_readdata_i,
  output logic                  mem_write_o,
  output logic [LANES-1:0]      mem_writeenable_o,
  output logic [WIDTH-1:0]      mem_writedata_o
);

  if ((WIDTH % GRANULITY) != 0) begin : g_bad_cfg
    $fatal(1, "armleocpu_mem_wbuf: WIDTH must be a multiple of GRANULITY");
  end

`ifdef ARMLEOCPU_MEM_WBUF_INIT_EN
  localparam wbuf_state_t RST_STATE = ST_INIT;
  localparam logic        RST_BUSY  = 1'b1;
`else
  localparam wbuf_state_t RST_STATE = ST_RUN;
  localparam logic        RST_BUSY  = 1'b0;
`endif

  localparam logic [ELEMENTS_W-1:0] LAST_ADDR = {ELEMENTS_W{1'b1}};

  wbuf_state_t           state_q, state_d;
  logic [ELEMENTS_W-1:0] init_cnt_q, init_cnt_d;
  logic                  buf_valid_q, buf_valid_d;
  logic [ELEMENTS_W-1:0] buf_address_q;
  logic [LANES-1:0]      buf_writeenable_q;
  logic [WIDTH-1:0]      buf_writedata_q;
  logic [LANES-1:0]      fwd_enable_q, fwd_enable_d;
  logic [WIDTH-1:0]      fwd_data_q;
  logic                  resp_valid_q;

  logic running, rd_acc, wr_acc, drain, hit;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + ELEMENTS_W'(1);
      if (init_cnt_q == LAST_ADDR) begin
        state_d = ST_RUN;
      end
    end
  end

  // Every output is masked while rst_i is high so reset takes effect in the same cycle.
  always_comb begin
    running = !rst_i && (state_q == ST_RUN);
    rd_acc  = running && req_valid_i && !req_write_i;
    wr_acc  = running && req_valid_i && req_write_i;
    drain   = running && !rd_acc && buf_valid_q;
    hit     = buf_valid_q && (buf_address_q == req_address_i);

    mem_address_o     = '0;
    mem_read_o        = 1'b0;
    mem_write_o       = 1'b0;
    mem_writeenable_o = '0;
    mem_writedata_o   = '0;
    if (!rst_i && state_q == ST_INIT) begin
      mem_address_o     = init_cnt_q;
      mem_write_o       = 1'b1;
      mem_writeenable_o = '1;
    end else if (rd_acc) begin
      mem_address_o = req_address_i;
      mem_read_o    = 1'b1;
    end else if (drain) begin
      mem_address_o     = buf_address_q;
      mem_write_o       = 1'b1;
      mem_writeenable_o = buf_writeenable_q;
      mem_writedata_o   = buf_writedata_q;
    end

    buf_valid_d = buf_valid_q;
    if (wr_acc) begin
      buf_valid_d = 1'b1;
    end else if (drain) begin
      buf_valid_d = 1'b0;
    end

    fwd_enable_d = fwd_enable_q;
    if (rd_acc) begin
      fwd_enable_d = hit ? buf_writeenable_q : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RST_STATE;
      init_cnt_q   <= '0;
      buf_valid_q  <= 1'b0;
      fwd_enable_q <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      buf_valid_q  <= buf_valid_d;
      fwd_enable_q <= fwd_enable_d;
      resp_valid_q <= rd_acc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      buf_address_q     <= req_address_i;
      buf_writeenable_q <= req_writeenable_i;
      buf_writedata_q   <= req_writedata_i;
    end
    if (rd_acc) begin
      fwd_data_q <= buf_writedata_q;
    end
  end

  armleocpu_bytemerge #(
    .WIDTH     (WIDTH),
    .GRANULITY (GRANULITY)
  ) u_merge (
    .sel_i (fwd_enable_q),
    .a_i   (fwd_data_q),
    .b_i   (mem_readdata_i),
    .y_o   (resp_readdata_o)
  );

  assign req_ready_o  = running;
  assign resp_valid_o = resp_valid_q && !rst_i;
  assign busy_o       = rst_i ? RST_BUSY : ((state_q == ST_INIT) || buf_valid_q);

endmodule

// File: tb/tb_armleocpu_mem_wbuf.sv
// Bench for armleocpu_mem_wbuf: behavioural array, directed vector table,
// random traffic against a program-order shadow memory, and mid-operation reset.
module tb_armleocpu_mem_wbuf;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int LN = 4;
  localparam int DEPTH = 128;

`ifdef ARMLEOCPU_MEM_WBUF_INIT_EN
  localparam bit INIT_ON = 1'b1;
`else
  localparam bit INIT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_write;
  logic [AW-1:0] req_address;
  logic [LN-1:0] req_we;
  logic [DW-1:0] req_wd;
  logic resp_valid;
  logic [DW-1:0] resp_rd;
  logic busy;
  logic [AW-1:0] mem_address;
  logic mem_read, mem_write;
  logic [DW-1:0] mem_rdata;
  logic [LN-1:0] mem_we;
  logic [DW-1:0] mem_wdata;

  always #5 clk = ~clk;

  armleocpu_mem_wbuf #(.ELEMENTS_W(AW), .WIDTH(DW), .GRANULITY(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_address_i(req_address), .req_writeenable_i(req_we), .req_writedata_i(req_wd),
    .resp_valid_o(resp_valid), .resp_readdata_o(resp_rd), .busy_o(busy),
    .mem_address_o(mem_address), .mem_read_o(mem_read), .mem_readdata_i(mem_rdata),
    .mem_write_o(mem_write), .mem_writeenable_o(mem_we), .mem_writedata_o(mem_wdata)
  );

  // Behavioural read-first 1RW array with per-byte enables.
  logic [DW-1:0] arr [DEPTH];
  logic preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) arr[i] <= 32'hDEAD_BEEF;
      arr[7] <= 32'h7777_7777;
    end else begin
      if (mem_read) mem_rdata <= arr[mem_address];
      if (mem_write)
        for (int l = 0; l < LN; l++)
          if (mem_we[l]) arr[mem_address][l*8 +: 8] <= mem_wdata[l*8 +: 8];
    end
  end

  // Flags any write of the discarded buffered word to address 7.
  logic watch = 1'b0;
  logic bad_write = 1'b0;
  always @(negedge clk)
    if (watch && mem_write && mem_address == 7'd7 && mem_wdata == 32'hFFFF_FFFF) bad_write <= 1'b1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [LN-1:0] we, input logic [DW-1:0] wd);
    req_valid = v; req_write = w; req_address = a; req_we = we; req_wd = wd;
  endtask

  typedef struct {
    logic vld, wr;
    logic [AW-1:0] addr;
    logic [LN-1:0] we;
    logic [DW-1:0] wd;
    logic e_rd, e_wr, e_busy, e_rv;
    logic [AW-1:0] e_addr;
    logic [LN-1:0] e_we;
    logic [DW-1:0] e_wdata, e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic wr, input logic [AW-1:0] addr,
                              input logic [LN-1:0] we, input logic [DW-1:0] wd,
                              input logic e_rd, input logic e_wr, input logic [AW-1:0] e_addr,
                              input logic [LN-1:0] e_we, input logic [DW-1:0] e_wdata,
                              input logic e_busy, input logic e_rv, input logic [DW-1:0] e_rdata);
    vec_t v;
    v.vld = vld; v.wr = wr; v.addr = addr; v.we = we; v.wd = wd;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_we = e_we; v.e_wdata = e_wdata;
    v.e_busy = e_busy; v.e_rv = e_rv; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int k;
    for (k = 0; k < 300 && !req_ready; k++) @(negedge clk);
    if (!req_ready) chk(name, {31'b0, req_ready}, 32'd1);
  endtask

  vec_t vecs [12];
  logic [DW-1:0] gold [8];
  logic [DW-1:0] exp_prev, exp_cur, keep7;
  logic pend_prev, pend_cur;

  initial begin
    //          vld wr addr we     wdata          | rd wr addr we     wdata          busy rv rdata
    vecs[0]  = mk(1, 1, 5, 4'hF, 32'hAABB_CCDD,   0, 0, 0, 4'h0, 32'h0,            0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 0, 4'h0, 32'h0,           0, 1, 5, 4'hF, 32'hAABB_CCDD,    1, 0, 32'h0);
    vecs[2]  = mk(1, 0, 5, 4'h0, 32'h0,           1, 0, 5, 4'h0, 32'h0,            0, 0, 32'h0);
    vecs[3]  = mk(0, 0, 0, 4'h0, 32'h0,           0, 0, 0, 4'h0, 32'h0,            0, 1, 32'hAABB_CCDD);
    vecs[4]  = mk(1, 1, 3, 4'h3, 32'h0000_1234,   0, 0, 0, 4'h0, 32'h0,            0, 0, 32'h0);
    vecs[5]  = mk(1, 0, 3, 4'h0, 32'h0,           1, 0, 3, 4'h0, 32'h0,            1, 0, 32'h0);
    vecs[6]  = mk(0, 0, 0, 4'h0, 32'h0,           0, 1, 3, 4'h3, 32'h0000_1234,    1, 1, 32'hDEAD_1234);
    vecs[7]  = mk(1, 1, 1, 4'hF, 32'h1111_1111,   0, 0, 0, 4'h0, 32'h0,            0, 0, 32'h0);
    vecs[8]  = mk(1, 1, 2, 4'hF, 32'h2222_2222,   0, 1, 1, 4'hF, 32'h1111_1111,    1, 0, 32'h0);
    vecs[9]  = mk(1, 1, 3, 4'hF, 32'h3333_3333,   0, 1, 2, 4'hF, 32'h2222_2222,    1, 0, 32'h0);
    vecs[10] = mk(0, 0, 0, 4'h0, 32'h0,           0, 1, 3, 4'hF, 32'h3333_3333,    1, 0, 32'h0);
    vecs[11] = mk(0, 0, 0, 4'h0, 32'h0,           0, 0, 0, 4'h0, 32'h0,            0, 0, 32'h0);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_busy", {31'b0, busy}, {31'b0, INIT_ON});
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    if (INIT_ON) begin
      for (int i = 0; i < DEPTH; i++) begin
        chk("init_wr", {31'b0, mem_write}, 32'd1);
        chk("init_addr", {25'b0, mem_address}, i);
        chk("init_data_en", {mem_wdata[27:0], mem_we}, 32'h0000_000F);
        chk("init_ready_busy", {30'b0, req_ready, busy}, 32'd1);
        @(negedge clk);
      end
    end
    chk("first_ready", {31'b0, req_ready}, 32'd1);
    chk("first_busy", {31'b0, busy}, 32'd0);

    @(posedge clk); #1 preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].vld, vecs[i].wr, vecs[i].addr, vecs[i].we, vecs[i].wd);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {31'b0, req_ready}, 32'd1);
      chk($sformatf("v%0d_mem_read", i), {31'b0, mem_read}, {31'b0, vecs[i].e_rd});
      chk($sformatf("v%0d_mem_write", i), {31'b0, mem_write}, {31'b0, vecs[i].e_wr});
      chk($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].e_busy});
      chk($sformatf("v%0d_resp_valid", i), {31'b0, resp_valid}, {31'b0, vecs[i].e_rv});
      if (vecs[i].e_rd || vecs[i].e_wr)
        chk($sformatf("v%0d_mem_addr", i), {25'b0, mem_address}, {25'b0, vecs[i].e_addr});
      if (vecs[i].e_wr) begin
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
        chk($sformatf("v%0d_mem_we", i), {28'b0, mem_we}, {28'b0, vecs[i].e_we});
      end
      if (vecs[i].e_rv)
        chk($sformatf("v%0d_resp_data", i), resp_rd, vecs[i].e_rdata);
    end

    // Random traffic on 8 addresses to exercise forwarding and drain under read pressure.
    @(posedge clk); #1 drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    for (int a = 0; a < 8; a++) gold[a] = arr[a];
    pend_prev = 1'b0;
    exp_prev = '0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      drive(($urandom % 4) != 0, $urandom % 2, AW'($urandom % 8), LN'($urandom), $urandom);
      pend_cur = 1'b0;
      exp_cur = '0;
      if (req_valid && req_write) begin
        for (int l = 0; l < LN; l++)
          if (req_we[l]) gold[req_address[2:0]][l*8 +: 8] = req_wd[l*8 +: 8];
      end else if (req_valid) begin
        pend_cur = 1'b1;
        exp_cur = gold[req_address[2:0]];
      end
      @(negedge clk);
      chk("rnd_resp_valid", {31'b0, resp_valid}, {31'b0, pend_prev});
      if (pend_prev) chk("rnd_resp_data", resp_rd, exp_prev);
      chk("rnd_port_excl", {31'b0, mem_read && mem_write}, 32'd0);
      pend_prev = pend_cur;
      exp_prev = exp_cur;
    end
    @(posedge clk); #1 drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int a = 0; a < 8; a++) chk($sformatf("drain_arr%0d", a), arr[a], gold[a]);
    chk("drain_busy", {31'b0, busy}, 32'd0);

    // Reset while a write to 7 is parked: it must never reach the array.
    keep7 = gold[7];
    watch = 1'b1;
    @(posedge clk); #1 drive(1, 1, 7, 4'hF, 32'hFFFF_FFFF);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0); rst = 1'b1;
    @(negedge clk);
    chk("mrst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("mrst_ready", {31'b0, req_ready}, 32'd0);
    chk("mrst_busy", {31'b0, busy}, {31'b0, INIT_ON});
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    wait_ready("mrst_ready_timeout");
    repeat (3) @(posedge clk);
    #1 drive(1, 0, 7, 0, 0);
    @(negedge clk);
    chk("mrst_read7_issue", {31'b0, mem_read}, 32'd1);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mrst_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("mrst_resp_data", resp_rd, INIT_ON ? 32'h0 : keep7);
    chk("mrst_no_write7", {31'b0, bad_write}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/armleocpu_mem_wbuf.md
# armleocpu_mem_wbuf

Single-entry write buffer and request sequencer placed directly upstream of a byte-enable, read-first, single-port memory array (1RW with per-lane write enables). Accepts one read or write request per cycle from a client (cache data/tag array logic) and parks writes in a one-entry buffer. The buffer retires in cycles the memory port is not needed for a read. Reads that hit the buffered address get the buffered bytes forwarded, so the client always sees program-order data.

## Interface
- ELEMENTS_W, 7, address width; array depth 2**ELEMENTS_W
- WIDTH, 32, data width in bits
- GRANULITY, 8, bits per write-enable lane; WIDTH % GRANULITY == 0 (simulation $fatal otherwise)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  client request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_write  in  1  1 = write, 0 = read
- req_address  in  ELEMENTS_W  element address
- req_writeenable  in  WIDTH/GRANULITY  lane enables (writes only)
- req_writedata  in  WIDTH  write data
- resp_valid  out  1  read data valid, one cycle after accepted read
- resp_readdata  out  WIDTH  merged read data
- busy  out  1  init in progress or buffer occupied
- mem_address  out  ELEMENTS_W  to array
- mem_read  out  1  to array
- mem_readdata  in  WIDTH  from array, valid cycle after mem_read, held until next read
- mem_write  out  1  to array
- mem_writeenable  out  WIDTH/GRANULITY  to array
- mem_writedata  out  WIDTH  to array

## Operation
- State: INIT, RUN. Buffer regs: buf_valid, buf_address, buf_writeenable, buf_writedata.
- Port use per cycle in RUN, priority order: (1) accepted read -> mem_read=1, mem_address=req_address; (2) else buf_valid -> mem_write=1 with buffer contents, buf_valid cleared at edge.
- Accepted write: buffer loaded at edge. If buffer already valid it drains the same cycle (no read possible that cycle), so req_ready=1 throughout RUN; writes sustain 1/cycle.
- Accepted read with buf_valid && buf_address==req_address: capture buf_writeenable/buf_writedata into fwd regs; else capture fwd enable = 0.
- resp_readdata: per lane, fwd lane enabled ? fwd data : mem_readdata. Holds value until next accepted read.
- Consecutive reads may hold the buffer indefinitely; correctness is kept by forwarding.
- Mem outputs are combinational from state/request; mem_read and mem_write never both 1.

## Timing
- Reset (during rst): req_ready=0, resp_valid=0, busy=1 only if init compiled in (else 0), mem_read=0, mem_write=0, buf_valid=0, fwd enable=0, state = INIT or RUN per config.
- Read latency: accept in cycle N -> resp_valid=1 in N+1 only.
- Write visible in array: earliest accept cycle N+1 (drained in first read-free cycle).
- Reset mid-operation: buffered write discarded; init restarts at address 0.

## Configuration
- ARMLEOCPU_MEM_WBUF_INIT_EN defined: after reset, state INIT walks counter 0..2**ELEMENTS_W-1, one per cycle, mem_write=1, all lanes enabled, data 0; req_ready=0, busy=1; after last address -> RUN. Init takes exactly 2**ELEMENTS_W cycles.
- Not defined: reset enters RUN directly; req_ready=1 first cycle after rst deasserts; array contents undefined.

## Structure
- Shared package: state encoding (INIT/RUN), lane-count constant derivation helper.
- One natural sub-module: armleocpu_bytemerge (per-lane mux of two WIDTH words under lane mask), used for forward merge.
- Array itself is instantiated by parent, not here.

## Test plan
- Init on: after rst, 128 cycles of mem_write with address 0..127, data 0, enables 4'hF; req_ready rises cycle 129.
- Write addr 5 data 32'hAABBCCDD en 4'hF, then idle -> mem_write in next cycle, addr 5; read addr 5 -> resp 32'hAABBCCDD.
- Write addr 3 en 4'b0011 data 32'h0000_1234 (array holds 32'hDEAD_BEEF), immediately read addr 3 -> resp 32'hDEAD_1234; mem_write for addr 3 occurs cycle after read.
- Back-to-back writes addr 1,2,3 -> three consecutive mem_write pulses, req_ready constant 1.
- rst asserted while buf_valid (addr 7) -> no mem_write to 7 afterwards; read 7 returns pre-write data (init off) or 0 (init on).
